// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl
// Write-side pointer controller for an asynchronous FIFO. It owns the binary
// and Gray write pointers and drives the memory write port. It brings the
// read-side Gray pointer into this clock domain and derives a pessimistic
// occupancy from it. FULL, ALMOST_FULL and W_LEVEL are all registered, and
// OVERFLOW latches any write attempt made while full.
module fifo_wr_ptr_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    localparam int A          = $clog2(FIFO_DEPTH)
) (
    input  logic         W_CLK,
    input  logic         W_RST,
    input  logic         W_INC,
    input  logic         W_CLR_ERR,
    input  logic [A:0]   R_PTR_GRAY,
    input  logic [A:0]   AF_LEVEL,
    output logic         W_EN,
    output logic [A-1:0] W_ADDR,
    output logic [A:0]   W_PTR,
    output logic         FULL,
    output logic         ALMOST_FULL,
    output logic [A:0]   W_LEVEL,
    output logic         OVERFLOW
);

    // Occupancy value that means "every entry holds unread data".
    localparam logic [A:0] DEPTH_L = (A+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [A:0] wbin_reg;
    logic [A:0] wbin_next;
    logic [A:0] wgray_reg;
    logic [A:0] wgray_next;

    logic [A:0] rsync_reg [SYNC_STAGES];
    logic [A:0] rgray_s;
    logic [A:0] rbin_s;

    logic [A:0] level_reg;
    logic [A:0] level_next;
    logic       full_reg;
    logic       full_next;
    logic       af_reg;
    logic       af_next;
    logic       ovf_reg;
    logic       ovf_next;

    logic       wr_accept;
    logic       wr_reject;

    // ------------------------------------------------------------------
    // Write acceptance
    // ------------------------------------------------------------------
    // A write is taken only while the registered FULL flag is low. The
    // memory captures on the same edge, so the enable is combinational.
    assign wr_accept = W_INC & ~full_reg;
    assign wr_reject = W_INC &  full_reg;

    // Next binary pointer: advance by one on an accepted write. It wraps
    // naturally modulo 2*FIFO_DEPTH because of its A+1 bit width.
    always_comb begin
        wbin_next = wbin_reg;
        if (wr_accept) begin
            wbin_next = wbin_reg + 1'b1;
        end
    end

    // Gray encoding of the next pointer. It is registered alongside wbin, so
    // W_PTR never lags the binary counter.
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // ------------------------------------------------------------------
    // Read pointer synchroniser
    // ------------------------------------------------------------------
    // Multi-flop chain for the asynchronous Gray read pointer. Only one
    // bit changes per read, so any sampled value is either the old or
    // the new pointer.
    always_ff @(posedge W_CLK) begin
        if (!W_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rsync_reg[i] <= '0;
            end
        end else begin
            rsync_reg[0] <= R_PTR_GRAY;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rsync_reg[i] <= rsync_reg[i-1];
            end
        end
    end

    assign rgray_s = rsync_reg[SYNC_STAGES-1];

    // Gray-to-binary conversion. Each binary bit is the XOR of all Gray
    // bits at and above it. It is written per bit so that no bit depends
    // on another bit of the same vector.
    generate
        for (genvar gi = 0; gi <= A; gi++) begin : g_gray2bin
            assign rbin_s[gi] = ^rgray_s[A:gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Occupancy and flags
    // ------------------------------------------------------------------
    // Level is computed from the post-write pointer and the synchronised
    // read pointer. The read pointer is stale, so the level can only
    // overstate occupancy. That keeps FULL safe.
    assign level_next = wbin_next - rbin_s;
    assign full_next  = (level_next == DEPTH_L);

    // A zero threshold disables ALMOST_FULL. A threshold above the depth
    // can never be reached because level_next tops out at FIFO_DEPTH.
    assign af_next = (AF_LEVEL != '0) && (level_next >= AF_LEVEL);

    // Sticky overflow. A new rejected write wins over a clear in the same
    // cycle, so an error can never be lost.
    always_comb begin
        ovf_next = ovf_reg;
        if (wr_reject) begin
            ovf_next = 1'b1;
        end else if (W_CLR_ERR) begin
            ovf_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered pointer and status state
    // ------------------------------------------------------------------
    // Register pointers and flags. Reset discards all write-side state;
    // a W_INC present during reset has no effect.
    always_ff @(posedge W_CLK) begin
        if (!W_RST) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            af_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            af_reg    <= af_next;
            ovf_reg   <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign W_EN        = wr_accept;
    assign W_ADDR      = wbin_reg[A-1:0];
    assign W_PTR       = wgray_reg;
    assign FULL        = full_reg;
    assign ALMOST_FULL = af_reg;
    assign W_LEVEL     = level_reg;
    assign OVERFLOW    = ovf_reg;

endmodule
